column_stream_writer: RTL and testbench

Transmit side of the column link into column_decoder. Accepts 28-bit ray-cast column records from the ray engine over a valid/ready handshake and buffers them in a small FIFO. Each record is serialized into two 16-bit Avalon-MM master write beats in the decoder's two-stage format. After NUM_COLS columns it emits one terminator record and pulses frame_done.

---
 rtl/column_stream_writer.sv | 222 ++++++++++++++++++++++
 tb/tb_column_stream_writer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/column_stream_writer.sv
// Column link transmitter: buffers 28-bit column records in a small FIFO and
// serializes each into two 16-bit Avalon-MM write beats, closing a frame with a terminator.
module column_stream_writer #(
  parameter int NUM_COLS   = 640,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 4,
  parameter int COL_ADDR   = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [27:0]       col_data,
  input  logic              col_valid,
  output logic              col_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic              avm_chipselect,
  output logic [15:0]       avm_writedata,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic [9:0]        col_count,
  output logic              frame_done
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam int          PW        = AW + 1;
  localparam logic [9:0]  LAST_COL  = 10'(NUM_COLS - 1);
  localparam logic [15:0] TERM_WORD = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BEAT0 = 3'd1,
    S_BEAT1 = 3'd2,
    S_TERM0 = 3'd3,
    S_TERM1 = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  logic [27:0]   mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] fill_s;
  logic [AW-1:0] rd_idx_s;
  logic [AW-1:0] nxt_idx_s;
  logic          fifo_empty_s;
  logic          fifo_full_s;
  logic          push_s;
  logic          pop_s;
  logic          accept_s;
  logic          more_s;
  logic          last_col_s;
  logic [27:0]   head_s;
  logic [27:0]   next_s;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          avm_write_r;
  logic [15:0]   avm_writedata_r;
  logic [9:0]    col_count_r;
  logic          frame_done_r;
  logic          write_nxt_s;
  logic [15:0]   data_nxt_s;
  logic [9:0]    count_nxt_s;
  logic          fd_nxt_s;

  // Pointer-derived FIFO status; pointers carry one extra wrap bit.
  always_comb begin
    fill_s       = wr_ptr_r - rd_ptr_r;
    fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    fifo_full_s  = (fill_s == PW'(FIFO_DEPTH));
    rd_idx_s     = rd_ptr_r[AW-1:0];
    nxt_idx_s    = rd_idx_s + AW'(1);
    head_s       = mem_r[rd_idx_s];
    next_s       = mem_r[nxt_idx_s];
    accept_s     = avm_write_r & ~avm_waitrequest;
    push_s       = col_valid & ~fifo_full_s;
    pop_s        = (state_r == S_BEAT1) & accept_s;
    more_s       = (fill_s > PW'(1));
    last_col_s   = (col_count_r == LAST_COL);
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= col_data;
    end
  end

  // FIFO pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE:  if (!fifo_empty_s) state_nxt_s = S_BEAT0; else state_nxt_s = S_IDLE;
      S_BEAT0: if (accept_s) state_nxt_s = S_BEAT1; else state_nxt_s = S_BEAT0;
      S_BEAT1: begin
        if (!accept_s) begin
          state_nxt_s = S_BEAT1;
        end else if (last_col_s) begin
          state_nxt_s = S_TERM0;
        end else if (more_s) begin
          state_nxt_s = S_BEAT0;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_TERM0: if (accept_s) state_nxt_s = S_TERM1; else state_nxt_s = S_TERM0;
      S_TERM1: if (accept_s) state_nxt_s = S_DONE; else state_nxt_s = S_TERM1;
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Next values of the registered bus outputs; they hold unless a beat is accepted.
  always_comb begin
    write_nxt_s = avm_write_r;
    data_nxt_s  = avm_writedata_r;
    count_nxt_s = col_count_r;
    fd_nxt_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          write_nxt_s = 1'b1;
          data_nxt_s  = {3'b000, head_s[27:15]};
        end else begin
          write_nxt_s = 1'b0;
        end
      end
      S_BEAT0: begin
        if (accept_s) begin
          data_nxt_s = {1'b0, head_s[14:0]};
        end else begin
          data_nxt_s = avm_writedata_r;
        end
      end
      S_BEAT1: begin
        if (accept_s) begin
          count_nxt_s = col_count_r + 10'd1;
          if (last_col_s) begin
            data_nxt_s = TERM_WORD;
          end else if (more_s) begin
            data_nxt_s = {3'b000, next_s[27:15]};
          end else begin
            write_nxt_s = 1'b0;
          end
        end else begin
          count_nxt_s = col_count_r;
        end
      end
      S_TERM0: begin
        if (accept_s) begin
          data_nxt_s = TERM_WORD;
        end else begin
          data_nxt_s = avm_writedata_r;
        end
      end
      S_TERM1: begin
        if (accept_s) begin
          write_nxt_s = 1'b0;
          fd_nxt_s    = 1'b1;
        end else begin
          write_nxt_s = avm_write_r;
        end
      end
      S_DONE: begin
        write_nxt_s = 1'b0;
        count_nxt_s = 10'd0;
      end
      default: begin
        write_nxt_s = 1'b0;
        count_nxt_s = 10'd0;
      end
    endcase
  end

  // Output registers; reset abandons any beat in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_write_r     <= 1'b0;
      avm_writedata_r <= 16'h0000;
      col_count_r     <= 10'd0;
      frame_done_r    <= 1'b0;
    end else begin
      avm_write_r     <= write_nxt_s;
      avm_writedata_r <= data_nxt_s;
      col_count_r     <= count_nxt_s;
      frame_done_r    <= fd_nxt_s;
    end
  end

  assign col_ready      = ~fifo_full_s;
  assign avm_address    = ADDR_W'(COL_ADDR);
  assign avm_write      = avm_write_r;
  assign avm_chipselect = avm_write_r;
  assign avm_writedata  = avm_writedata_r;
  assign busy           = (state_r != S_IDLE) | ~fifo_empty_s;
  assign col_count      = col_count_r;
  assign frame_done     = frame_done_r;

endmodule

// File: tb/tb_column_stream_writer.sv
// Bench for column_stream_writer: a beat-queue model built from pushed records,
// checked every cycle on the falling edge, plus hand-computed literal expectations.
module tb_column_stream_writer;

  localparam int NUM_COLS   = 640;
  localparam int FIFO_DEPTH = 4;
  localparam int ADDR_W     = 4;
  localparam int COL_ADDR   = 0;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [27:0]       col_data = 28'h0;
  logic              col_valid = 1'b0;
  logic              col_ready;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic              avm_chipselect;
  logic [15:0]       avm_writedata;
  logic              avm_waitrequest;
  logic              busy;
  logic [9:0]        col_count;
  logic              frame_done;

  logic wr_force = 1'b0;
  logic rand_en  = 1'b0;
  logic rand_bit = 1'b0;

  assign avm_waitrequest = wr_force | (rand_en & rand_bit);

  always #10 clk = ~clk;

  column_stream_writer #(
    .NUM_COLS(NUM_COLS), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .COL_ADDR(COL_ADDR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .col_data(col_data), .col_valid(col_valid),
    .col_ready(col_ready), .avm_address(avm_address), .avm_write(avm_write),
    .avm_chipselect(avm_chipselect), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .busy(busy), .col_count(col_count),
    .frame_done(frame_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  always @(posedge clk) begin
    #1;
    rand_bit = ($urandom_range(0, 2) == 0);
  end

  // Model: each accepted push appends its two beats; every NUM_COLS records add two terminators.
  logic [17:0] exp_q[$];
  logic [15:0] acc_log[$];
  int          recs_in_frame = 0;
  int          exp_cnt = 0;
  bit          exp_fd = 1'b0;
  bit          stall_prev = 1'b0;
  logic [15:0] data_prev = 16'h0;
  int          write_cycles = 0;
  int          fd_pulses = 0;
  int          push_cnt = 0;

  always @(negedge clk) begin
    logic [17:0] e;
    if (!reset_n) begin
      exp_q.delete();
      recs_in_frame = 0;
      exp_cnt = 0;
      exp_fd = 1'b0;
      stall_prev = 1'b0;
    end else begin
      check("frame_done", {31'b0, frame_done}, {31'b0, exp_fd});
      check("col_count", {22'b0, col_count}, exp_cnt);
      check("chipselect", {31'b0, avm_chipselect}, {31'b0, avm_write});
      check("address", {28'b0, avm_address}, COL_ADDR);
      if (exp_fd) begin
        fd_pulses++;
        exp_cnt = 0;
      end
      if (stall_prev) begin
        check("hold_write", {31'b0, avm_write}, 32'd1);
        check("hold_data", {16'b0, avm_writedata}, {16'b0, data_prev});
      end
      if (avm_write) write_cycles++;
      exp_fd = 1'b0;
      if (avm_write && !avm_waitrequest) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat", {16'b0, avm_writedata}, 32'h0001_0000);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", {16'b0, avm_writedata}, {16'b0, e[15:0]});
          acc_log.push_back(avm_writedata);
          if (e[17:16] == 2'd1) exp_cnt++;
          exp_fd = (e[17:16] == 2'd3);
        end
      end
      stall_prev = avm_write && avm_waitrequest;
      data_prev  = avm_writedata;
      if (col_valid && col_ready) begin
        push_cnt++;
        exp_q.push_back({2'd0, 3'b000, col_data[27:15]});
        exp_q.push_back({2'd1, 1'b0, col_data[14:0]});
        recs_in_frame++;
        if (recs_in_frame == NUM_COLS) begin
          exp_q.push_back({2'd2, 16'hFFFF});
          exp_q.push_back({2'd3, 16'hFFFF});
          recs_in_frame = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [27:0] d);
    logic r;
    col_data  = d;
    col_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      r = col_ready;
      tick();
      if (r) begin
        col_valid = 1'b0;
        return;
      end
    end
    col_valid = 1'b0;
    timeout_fail("push_timeout");
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy && exp_q.size() == 0) return;
      tick();
    end
    timeout_fail("drain_timeout");
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  int base_a;
  int base_w;
  int base_p;
  int base_fd;
  bit found;

  initial begin
    tick();
    tick();
    check("rst_write", {31'b0, avm_write}, 32'd0);
    check("rst_wdata", {16'b0, avm_writedata}, 32'd0);
    check("rst_count", {22'b0, col_count}, 32'd0);
    check("rst_fd", {31'b0, frame_done}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ready", {31'b0, col_ready}, 32'd1);
    reset_n = 1'b1;
    tick();

    // Single column: beats 1579 then 5EF1, starting the cycle after the push edge.
    base_w = write_cycles;
    push(28'hABCDEF1);
    check("t1_pre_write", {31'b0, avm_write}, 32'd0);
    tick();
    check("t1_b0_write", {31'b0, avm_write}, 32'd1);
    check("t1_b0_data", {16'b0, avm_writedata}, 32'h1579);
    tick();
    check("t1_b1_write", {31'b0, avm_write}, 32'd1);
    check("t1_b1_data", {16'b0, avm_writedata}, 32'h5EF1);
    tick();
    check("t1_end_write", {31'b0, avm_write}, 32'd0);
    check("t1_count", {22'b0, col_count}, 32'd1);
    wait_idle(20);
    check("t1_busy", {31'b0, busy}, 32'd0);
    check("t1_write_cycles", write_cycles - base_w, 32'd2);

    // Backpressure on beat 0 for five cycles.
    wr_force = 1'b1;
    push(28'h0123456);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_stall_write", {31'b0, avm_write}, 32'd1);
      check("t2_stall_data", {16'b0, avm_writedata}, 32'h0024);
    end
    tick();
    wr_force = 1'b0;
    check("t2_rel_data", {16'b0, avm_writedata}, 32'h0024);
    tick();
    check("t2_b1_data", {16'b0, avm_writedata}, 32'h3456);
    check("t2_b1_write", {31'b0, avm_write}, 32'd1);
    tick();
    check("t2_end_write", {31'b0, avm_write}, 32'd0);
    check("t2_count", {22'b0, col_count}, 32'd2);

    // Full FIFO: four records fill it, the fifth is held by the source.
    base_a = acc_log.size();
    base_p = push_cnt;
    wr_force = 1'b1;
    push(28'hFFFFFFF);
    push(28'h1234567);
    push(28'h7654321);
    push(28'h0F0F0F0);
    check("t3_ready_full", {31'b0, col_ready}, 32'd0);
    col_data  = 28'h5555555;
    col_valid = 1'b1;
    tick();
    tick();
    tick();
    check("t3_held_pushes", push_cnt - base_p, 32'd4);
    check("t3_ready_held", {31'b0, col_ready}, 32'd0);
    wr_force = 1'b0;
    push(28'h5555555);
    push(28'h0008005);
    wait_idle(100);
    check("t3_beats", acc_log.size() - base_a, 32'd12);
    check("t3_first", {16'b0, acc_log[base_a]}, 32'h1FFF);
    check("t3_second", {16'b0, acc_log[base_a + 1]}, 32'h7FFF);
    check("t3_last0", {16'b0, acc_log[base_a + 10]}, 32'h0001);
    check("t3_last1", {16'b0, acc_log[base_a + 11]}, 32'h0005);
    check("t3_count", {22'b0, col_count}, 32'd8);

    // Full frame with random stalls, then record 641 pushed during TERM0.
    apply_reset();
    base_a  = acc_log.size();
    base_fd = fd_pulses;
    rand_en = 1'b1;
    for (int i = 0; i < NUM_COLS; i++) begin
      push(28'($urandom()));
    end
    found = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (avm_write && avm_writedata == 16'hFFFF) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    wr_force = 1'b1;
    if (!found) timeout_fail("term_timeout");
    check("t4_term_count", {22'b0, col_count}, NUM_COLS);
    push(28'hABCDEF1);
    wr_force = 1'b0;
    wait_idle(200);
    rand_en = 1'b0;
    check("t4_beats", acc_log.size() - base_a, 2 * NUM_COLS + 4);
    check("t4_term0", {16'b0, acc_log[base_a + 2 * NUM_COLS]}, 32'hFFFF);
    check("t4_term1", {16'b0, acc_log[base_a + 2 * NUM_COLS + 1]}, 32'hFFFF);
    check("t4_next0", {16'b0, acc_log[base_a + 2 * NUM_COLS + 2]}, 32'h1579);
    check("t4_next1", {16'b0, acc_log[base_a + 2 * NUM_COLS + 3]}, 32'h5EF1);
    check("t4_fd_pulses", fd_pulses - base_fd, 32'd1);
    check("t4_count", {22'b0, col_count}, 32'd1);

    // Asynchronous reset during a stalled beat 1 with three records queued.
    wr_force = 1'b1;
    push(28'h0123456);
    push(28'h1111111);
    push(28'h2222222);
    push(28'h3333333);
    wr_force = 1'b0;
    tick();
    wr_force = 1'b1;
    check("t6_pre_write", {31'b0, avm_write}, 32'd1);
    check("t6_pre_data", {16'b0, avm_writedata}, 32'h3456);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_write", {31'b0, avm_write}, 32'd0);
    check("t6_rst_count", {22'b0, col_count}, 32'd0);
    check("t6_rst_busy", {31'b0, busy}, 32'd0);
    check("t6_rst_ready", {31'b0, col_ready}, 32'd1);
    tick();
    tick();
    reset_n  = 1'b1;
    wr_force = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("t6_post_write", {31'b0, avm_write}, 32'd0);
    check("t6_post_ready", {31'b0, col_ready}, 32'd1);
    check("t6_post_count", {22'b0, col_count}, 32'd0);
    check("t6_post_busy", {31'b0, busy}, 32'd0);
    check("leftover_beats", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
